// File: rtl/bg_vram_writer.sv
// Background VRAM writer: packs three palette indices per word and streams them into VRAM.
// Optional solid-fill mode is compiled in when BGW_FILL_EN is defined.
module bg_vram_writer #(
   parameter int ADDR_W = 11,
   parameter int PIX_W  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef BGW_FILL_EN
   input  logic                 fill,
   input  logic [PIX_W-1:0]     fill_index,
`endif
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W-1:0]    word_count,
   input  logic                 pix_valid,
   input  logic [PIX_W-1:0]     pix_data,
   output logic                 pix_ready,
   output logic [ADDR_W-1:0]    vram_addr,
   output logic [3*PIX_W-1:0]   vram_din,
   output logic                 vram_we,
   output logic                 busy,
   output logic                 done
);

   // state   | meaning
   // S_IDLE  | waiting for start
   // S_PACK  | collecting up to three pixels into word_q
   // S_WRITE | one-cycle write of the packed word
   // S_DONE  | one-cycle done pulse
   // S_FILL  | solid fill, one word per cycle (BGW_FILL_EN only)
   typedef enum logic [2:0] {
      S_IDLE,
      S_PACK,
      S_WRITE,
      S_DONE
`ifdef BGW_FILL_EN
      , S_FILL
`endif
   } state_t;

   localparam int WORD_W = 3*PIX_W;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_cnt, rem_cnt, last_addr;
   logic [1:0]          slot_cnt;
   logic [WORD_W-1:0]   word_q, last_din, wr_data;
   logic                start_acc, pix_acc, wr_fire, rem_last;
`ifdef BGW_FILL_EN
   logic [PIX_W-1:0]    fill_q;
`endif

   assign start_acc = (state == S_IDLE) && start;
   assign pix_acc   = (state == S_PACK) && pix_valid && !abort;
   assign rem_last  = (rem_cnt == ADDR_W'(1));

   always_comb begin
      wr_fire = (state == S_WRITE) && !abort;
      wr_data = word_q;
`ifdef BGW_FILL_EN
      if (state == S_FILL) begin
         wr_fire = !abort;
         wr_data = {3{fill_q}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (word_count == '0) state_nxt = S_DONE;
`ifdef BGW_FILL_EN
               else if (fill)        state_nxt = S_FILL;
`endif
               else                  state_nxt = S_PACK;
            end
         end
         S_PACK: begin
            if (abort)                               state_nxt = S_IDLE;
            else if (pix_valid && slot_cnt == 2'd2)  state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (abort)         state_nxt = S_IDLE;
            else if (rem_last) state_nxt = S_DONE;
            else               state_nxt = S_PACK;
         end
         S_DONE: state_nxt = S_IDLE;
`ifdef BGW_FILL_EN
         S_FILL: begin
            if (abort)         state_nxt = S_IDLE;
            else if (rem_last) state_nxt = S_DONE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_cnt  <= '0;
         rem_cnt   <= '0;
         slot_cnt  <= '0;
         word_q    <= '0;
         last_addr <= '0;
         last_din  <= '0;
`ifdef BGW_FILL_EN
         fill_q    <= '0;
`endif
      end else begin
         if (start_acc) begin
            addr_cnt <= base_addr;
            rem_cnt  <= word_count;
            slot_cnt <= '0;
`ifdef BGW_FILL_EN
            fill_q   <= fill_index;
`endif
         end
         if (pix_acc) begin
            case (slot_cnt)
               2'd0:    word_q[WORD_W-1  -: PIX_W] <= pix_data;
               2'd1:    word_q[2*PIX_W-1 -: PIX_W] <= pix_data;
               default: word_q[PIX_W-1:0]          <= pix_data;
            endcase
            slot_cnt <= slot_cnt + 2'd1;
         end
         // address wraps naturally at 2^ADDR_W
         if (wr_fire) begin
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            rem_cnt   <= rem_cnt - ADDR_W'(1);
            slot_cnt  <= '0;
            last_addr <= addr_cnt;
            last_din  <= wr_data;
         end
      end
   end

   // bus shows the live word only while writing, otherwise the last word written
   assign vram_we   = wr_fire;
   assign vram_addr = wr_fire ? addr_cnt : last_addr;
   assign vram_din  = wr_fire ? wr_data  : last_din;
   assign pix_ready = (state == S_PACK);
   assign done      = (state == S_DONE) && !abort;
`ifdef BGW_FILL_EN
   assign busy      = (state == S_PACK) || (state == S_WRITE) || (state == S_FILL);
`else
   assign busy      = (state == S_PACK) || (state == S_WRITE);
`endif

endmodule

// File: tb/tb_bg_vram_writer.sv
// Randomized bench for bg_vram_writer against a transfer-level reference model.
// Define BGW_FILL_EN for both files to also exercise solid fill.
module tb_bg_vram_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [10:0] base_addr = '0;
   logic [10:0] word_count = '0;
   logic        pix_valid = 1'b0;
   logic [2:0]  pix_data = '0;
   logic        pix_ready;
   logic [10:0] vram_addr;
   logic [8:0]  vram_din;
   logic        vram_we;
   logic        busy;
   logic        done;
`ifdef BGW_FILL_EN
   logic        fill = 1'b0;
   logic [2:0]  fill_index = '0;
`endif

   bg_vram_writer #(.ADDR_W(11), .PIX_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef BGW_FILL_EN
      .fill       (fill),
      .fill_index (fill_index),
`endif
      .start      (start),
      .abort      (abort),
      .base_addr  (base_addr),
      .word_count (word_count),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .vram_addr  (vram_addr),
      .vram_din   (vram_din),
      .vram_we    (vram_we),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   int         wr_addr_q[$];
   int         wr_data_q[$];
   int         wr_cyc_q[$];
   int         acc_cyc_q[$];
   int         done_cyc_q[$];
   logic [2:0] pix_q[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (vram_we) begin
            wr_addr_q.push_back(int'(vram_addr));
            wr_data_q.push_back(int'(vram_din));
            wr_cyc_q.push_back(cyc);
         end
         if (pix_valid && pix_ready) acc_cyc_q.push_back(cyc);
         if (done) done_cyc_q.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      acc_cyc_q.delete();
      done_cyc_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic feed(input int first, input int last, input int gap);
      int   idx;
      int   guard;
      logic acc;
      idx = first;
      guard = 0;
      while (idx < last && guard < 2000) begin
         pix_valid = ($urandom_range(0, 99) >= gap);
         pix_data  = pix_q[idx];
         @(negedge clk);
         acc = pix_valid && pix_ready;
         tick(1);
         if (acc) idx++;
         guard++;
      end
      pix_valid = 1'b0;
      if (idx < last) check_eq("feed_timeout", idx, last);
   endtask

   task automatic wait_done(input int budget);
      int guard;
      guard = 0;
      while (done_cyc_q.size() == 0 && guard < budget) begin
         tick(1);
         guard++;
      end
      if (done_cyc_q.size() == 0) check_eq("done_timeout", 0, 1);
      tick(2);
   endtask

   // Expected writes follow directly from the transfer: word i goes to (base+i) mod 2048
   // and holds pixels 3i,3i+1,3i+2 from MSB to LSB.
   task automatic compare_writes(input int base, input int cnt, input int start_cyc);
      int n;
      int exp_a;
      int exp_d;
      check_eq("wr_count", wr_addr_q.size(), cnt);
      n = (wr_addr_q.size() < cnt) ? wr_addr_q.size() : cnt;
      for (int i = 0; i < n; i++) begin
         exp_a = (base + i) % 2048;
         exp_d = int'(pix_q[3*i])*64 + int'(pix_q[3*i+1])*8 + int'(pix_q[3*i+2]);
         check_eq("wr_addr", wr_addr_q[i], exp_a);
         check_eq("wr_data", wr_data_q[i], exp_d);
         if (acc_cyc_q.size() > 3*i+2)
            check_eq("wr_latency", wr_cyc_q[i], acc_cyc_q[3*i+2] + 1);
         else
            check_eq("wr_before_third_pixel", acc_cyc_q.size(), 3*i+3);
      end
      check_eq("done_count", done_cyc_q.size(), 1);
      if (done_cyc_q.size() >= 1) begin
         if (cnt == 0)
            check_eq("done_cycle", done_cyc_q[0], start_cyc + 1);
         else if (wr_cyc_q.size() > 0)
            check_eq("done_cycle", done_cyc_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
      end
      check_eq("busy_after", busy, 0);
      check_eq("ready_after", pix_ready, 0);
      if (cnt > 0) begin
         check_eq("hold_addr", int'(vram_addr), (base + cnt - 1) % 2048);
         check_eq("hold_din", int'(vram_din),
                  int'(pix_q[3*cnt-3])*64 + int'(pix_q[3*cnt-2])*8 + int'(pix_q[3*cnt-1]));
      end
   endtask

   task automatic pulse_start(input int base, input int cnt);
      base_addr  = 11'(base);
      word_count = 11'(cnt);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic run_transfer(input int base, input int cnt, input int gap);
      int start_cyc;
      clear_mon();
      pix_q.delete();
      for (int i = 0; i < 3*cnt; i++) pix_q.push_back(3'($urandom_range(0, 7)));
      start_cyc = cyc;
      pulse_start(base, cnt);
      if (cnt > 0) check_eq("ready_after_start", pix_ready, 1);
      feed(0, 3*cnt, gap);
      wait_done(100);
      compare_writes(base, cnt, start_cyc);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int start_cyc;

      // reset and idle
      tick(3);
      rst_n = 1'b1;
      clear_mon();
      tick(10);
      check_eq("rst_we", vram_we, 0);
      check_eq("rst_addr", int'(vram_addr), 0);
      check_eq("rst_din", int'(vram_din), 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ready", pix_ready, 0);
      check_eq("idle_writes", wr_addr_q.size(), 0);

      // directed two-word transfer at full rate
      clear_mon();
      pix_q = '{3'd5, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4};
      start_cyc = cyc;
      pulse_start(0, 2);
      check_eq("ready_after_start", pix_ready, 1);
      check_eq("busy_after_start", busy, 1);
      feed(0, 6, 0);
      wait_done(50);
      compare_writes(0, 2, start_cyc);
      if (wr_data_q.size() == 2) begin
         check_eq("word0_literal", wr_data_q[0], 9'b101_111_001);
         check_eq("word1_literal", wr_data_q[1], 9'b010_011_100);
      end
      if (acc_cyc_q.size() >= 4) begin
         check_eq("rate_back_to_back", acc_cyc_q[1] - acc_cyc_q[0], 1);
         check_eq("rate_gap_for_write", acc_cyc_q[3] - acc_cyc_q[2], 2);
      end

      // address wrap with random stalls
      run_transfer(2047, 2, 40);

      // abort mid-word, then a fresh word
      clear_mon();
      pix_q.delete();
      for (int i = 0; i < 2; i++) pix_q.push_back(3'($urandom_range(0, 7)));
      pulse_start(5, 2);
      feed(0, 2, 0);
      abort = 1'b1;
      pix_valid = 1'b1;
      pix_data = 3'd7;
      tick(1);
      abort = 1'b0;
      pix_valid = 1'b0;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_ready", pix_ready, 0);
      tick(5);
      check_eq("abort_writes", wr_addr_q.size(), 0);
      check_eq("abort_done", done_cyc_q.size(), 0);
      run_transfer(10, 1, 0);

      // zero-length transfer
      run_transfer(123, 0, 0);

      // start while busy is ignored
      clear_mon();
      pix_q.delete();
      for (int i = 0; i < 3; i++) pix_q.push_back(3'($urandom_range(0, 7)));
      start_cyc = cyc;
      pulse_start(20, 1);
      feed(0, 1, 0);
      pulse_start(30, 3);
      feed(1, 3, 0);
      wait_done(50);
      compare_writes(20, 1, start_cyc);

      // random transfers
      for (int t = 0; t < 8; t++)
         run_transfer($urandom_range(0, 2047), $urandom_range(1, 4), $urandom_range(0, 60));

`ifdef BGW_FILL_EN
      clear_mon();
      fill = 1'b1;
      fill_index = 3'b101;
      start_cyc = cyc;
      pulse_start(100, 4);
      fill = 1'b0;
      wait_done(50);
      check_eq("fill_count", wr_addr_q.size(), 4);
      for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
         check_eq("fill_addr", wr_addr_q[i], 100 + i);
         check_eq("fill_data", wr_data_q[i], 9'b101_101_101);
         check_eq("fill_cycle", wr_cyc_q[i], start_cyc + 1 + i);
      end
      check_eq("fill_no_pixels", acc_cyc_q.size(), 0);
      check_eq("fill_done_count", done_cyc_q.size(), 1);
      if (done_cyc_q.size() >= 1) check_eq("fill_done_cycle", done_cyc_q[0], start_cyc + 5);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
